// File: rtl/seg_scan_mux.sv
// seg_scan_mux: four-digit multiplexed 7-segment scanner with frame-coherent display updates
//
// Ports:
//   clk_in     - clock, rising edge
//   reset      - asynchronous active-high reset
//   digits_in  - four BCD digits, [3:0] is digit0 (least significant)
//   load       - capture strobe for digits_in
//   seg        - active-low segments {g,f,e,d,c,b,a}, registered
//   an         - active-low digit enables, an[i] selects digit i, registered
//   frame_tick - one-cycle pulse after each complete four-digit scan, registered
//
// Parameters:
//   REFRESH_DIV  - clk_in cycles per digit slot (>= 4)
//   BLANK_CYCLES - all-off cycles at the start of each slot (0 .. REFRESH_DIV-1)
//
// Optional feature: define SEG_SCAN_LEADING_ZERO_BLANK_EN to blank leading zeros
// on digits 3..1; digit0 is always shown.
module seg_scan_mux #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [15:0] digits_in,
    input  logic        load,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);
    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} state_t;
    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] shadow_q, disp_q, disp_d;
    logic        wrap, frame_end, blank, zero_lead;
    logic [3:0]  nib, an_d;
    logic [6:0]  dec, seg_d;

    always_comb begin
        wrap      = cnt_q == 32'(REFRESH_DIV - 1);
        frame_end = wrap && state_q == DIG3;
        cnt_d     = wrap ? 32'd0 : cnt_q + 32'd1;
        state_d   = wrap ? state_t'(state_q + 2'd1) : state_q;
        // disp_q only moves at the frame boundary; a load in that very cycle wins over the shadow
        disp_d    = frame_end ? (load ? digits_in : shadow_q) : disp_q;
        nib       = disp_q[{state_q, 2'b00} +: 4];
        dec       = 7'b1111111;
        case (nib)
            4'd0: dec = 7'b1000000;
            4'd1: dec = 7'b1111001;
            4'd2: dec = 7'b0100100;
            4'd3: dec = 7'b0110000;
            4'd4: dec = 7'b0011001;
            4'd5: dec = 7'b0010010;
            4'd6: dec = 7'b0000010;
            4'd7: dec = 7'b1111000;
            4'd8: dec = 7'b0000000;
            4'd9: dec = 7'b0010000;
            default: dec = 7'b1111111;
        endcase
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        // the selected digit and everything above it are zero
        zero_lead = state_q != DIG0 && (disp_q >> {state_q, 2'b00}) == 16'd0;
`else
        zero_lead = 1'b0;
`endif
        blank     = cnt_q < 32'(BLANK_CYCLES);
        an_d      = blank ? 4'b1111 : ~(4'b0001 << state_q);
        seg_d     = (blank || zero_lead) ? 7'b1111111 : dec;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            state_q    <= DIG0;
            shadow_q   <= '0;
            disp_q     <= '0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            frame_tick <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            shadow_q   <= load ? digits_in : shadow_q;
            disp_q     <= disp_d;
            an         <= an_d;
            seg        <= seg_d;
            frame_tick <= frame_end;
        end
    end
endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, meaning clk_in cycles per digit slot; legal range >= 4.
REQ-002 SHALL have parameter BLANK_CYCLES, default 500, meaning all-off cycles at the start of each slot for ghosting suppression; legal range 0 to REFRESH_DIV-1.
REQ-003 SHALL have port clk_in, input, 1 bit: clock, rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port digits_in, input, 16 bits: four BCD digits; [3:0] is digit0 (least significant), [15:12] is digit3.
REQ-006 SHALL have port load, input, 1 bit: capture strobe for digits_in.
REQ-007 SHALL have port seg, output, 7 bits: active-low segments {g,f,e,d,c,b,a}, registered.
REQ-008 SHALL have port an, output, 4 bits: active-low digit enables, an[i] selects digit i, registered.
REQ-009 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at the end of each full scan, registered.

Function
REQ-010 SHALL capture digits_in into shadow register shadow_q on every rising clk_in edge where load=1.
REQ-011 SHALL use a 32-bit slot counter that counts 0 to REFRESH_DIV-1 and then wraps to 0.
REQ-012 SHALL run a scan FSM with states DIG0->DIG1->DIG2->DIG3->DIG0, advancing one state only on the counter wrap.
REQ-013 SHALL load display register disp_q on the DIG3->DIG0 transition; if load=1 in that same cycle, digits_in SHALL be loaded (bypass), otherwise shadow_q; disp_q SHALL change at no other time, giving frame-coherent updates.
REQ-014 SHALL, when counter < BLANK_CYCLES, drive an=4'b1111 and seg=7'b1111111.
REQ-015 SHALL, otherwise, drive an active-low one-hot for the current state (DIG0=1110, DIG1=1101, DIG2=1011, DIG3=0111) and seg as the decode of the selected disp_q nibble.
REQ-016 SHALL decode digits as 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-017 SHALL decode nibble values 10-15 to seg=1111111 (blank), with an still asserted for that digit.
REQ-018 SHALL register outputs with one cycle of latency from the counter/state values that produce them.
REQ-019 SHALL pulse frame_tick=1 for exactly one cycle, the cycle after the DIG3->DIG0 transition: one pulse per 4*REFRESH_DIV cycles.

Reset
REQ-020 SHALL, while reset=1, force counter=0, state=DIG0, shadow_q=0, disp_q=0, an=4'b1111, seg=7'b1111111, frame_tick=0, with no clock edge required.
REQ-021 SHALL, on reset deassertion, restart scanning from DIG0, counter=0; a mid-frame reset SHALL discard any pending shadow_q contents.

Configuration
REQ-022 SHALL, when macro SEG_SCAN_LEADING_ZERO_BLANK_EN is defined, drive seg=1111111 for digit i (i=1..3) when disp_q digit i and all more-significant digits are 0; digit0 is never blanked, and an timing is unchanged.
REQ-023 SHALL, when SEG_SCAN_LEADING_ZERO_BLANK_EN is undefined, display every digit per REQ-016/REQ-017.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-024 SHALL cover reset: assert reset during DIG2 mid-slot -> same cycle an=1111, seg=1111111, frame_tick=0; after release, first active slot is DIG0.
REQ-025 SHALL cover display sequence: load 16'h1234, run to the frame boundary -> slots show an=1110/seg=0011001, 1101/0110000, 1011/0100100, 0111/1111001; each slot shows 2 blank cycles, then 6 active.
REQ-026 SHALL cover frame coherence: load 16'h5678 during DIG1 -> the current frame keeps the old digits; the new value appears from the next DIG0.
REQ-027 SHALL cover the boundary bypass: load 16'h9999 exactly in the DIG3->DIG0 cycle -> the next frame shows 9 (0010000) on all digits.
REQ-028 SHALL cover non-BCD input and frame_tick: load 16'h00AF -> digits 0 and 1 show seg=1111111 with an active; frame_tick pulses exactly every 32 cycles.
REQ-029 SHALL cover leading-zero blanking: load 16'h0007 -> with SEG_SCAN_LEADING_ZERO_BLANK_EN, digits 3..1 show seg=1111111; without it, digits 3..1 show seg=1000000; digit0 shows 1111000 in both builds.
